ft_sample_packer: RTL and testbench
===================================

Name: ft_sample_packer

Overview:
Byte-stream packetizer and transmit buffer in the ft_shift_clk (60 MHz) domain. It sits directly upstream of the FT232H sync-FIFO write driver.
- Accepts 12-bit AD9221 samples through a valid/ready handshake.
- Wraps them in fixed-length frames: header, sequence byte, payload.
- Buffers the frame bytes in a first-word-fall-through byte FIFO.
- Presents fif_data/fifo_empty to the write driver and pops one byte for every byte the FT232H accepts.

Parameters:
SMP_PER_FRAME, 256, samples per frame (range 1..65535)
FIFO_AW, 10, byte FIFO address width (depth = 2**FIFO_AW)
HDR0, 8'hA5, first header byte
HDR1, 8'h5A, second header byte

Ports:
ft_shift_clk  in  1  60 MHz FT232H clock; all logic on rising edge
rst_n_i  in  1  asynchronous, active-low reset
en_i  in  1  framing enable; sampled only at frame start
smp_data_i  in  12  ADC sample
smp_valid_i  in  1  sample present
smp_ready_o  out  1  sample accepted when valid & ready at an edge
ft_txe_i  in  1  FT232H TXE# (low = FT232H can accept data)
ft_wr_n_i  in  1  WR# as driven by the write driver (low = write)
fif_data_o  out  8  FIFO head byte (FWFT)
fifo_empty_o  out  1  FIFO empty
fifo_level_o  out  FIFO_AW+1  bytes currently stored
ovf_o  out  1  sticky: a sample was offered while not ready
drop_cnt_o  out  16  saturating count of dropped samples

Behaviour:
- Reset (async, any time, including mid-frame): FIFO emptied, pointers 0.
  - fif_data_o=8'h00, fifo_empty_o=1, fifo_level_o=0.
  - smp_ready_o=0, ovf_o=0, drop_cnt_o=0.
  - Sequence counter 0; FSM enters S_H0.
  - A partially built frame is discarded.
- Frame format (2+1+2*SMP_PER_FRAME bytes), in order:
  - HDR0, HDR1, seq[7:0].
  - Per sample: hi byte {4'h0, d[11:8]}, then lo byte d[7:0].
- FSM states and transitions:
  - S_H0: if en_i=1 and FIFO not full, write HDR0 and go to S_H1. Otherwise stay.
  - S_H1: if not full, write HDR1 and go to S_SEQ.
  - S_SEQ: if not full, write seq and go to S_SHI. Sample counter is cleared.
  - S_SHI: smp_ready_o=1 iff free entries >= 2.
    - On valid & ready: write hi byte, latch lo byte, go to S_SLO.
  - S_SLO: write the latched lo byte unconditionally (space guaranteed), increment the sample counter.
    - If count = SMP_PER_FRAME: increment seq (8-bit, wraps FF->00) and go to S_H0.
    - Otherwise go to S_SHI.
- smp_ready_o is a registered or state-decoded output. It is 0 in every state other than S_SHI, so throughput is at most 1 sample per 2 clocks.
- en_i deasserted mid-frame has no effect; the current frame always completes.
- Drop accounting: at any edge with smp_valid_i=1 and smp_ready_o=0:
  - ovf_o is set to 1 (cleared only by reset).
  - drop_cnt_o increments and saturates at 16'hFFFF.
- FIFO:
  - Write and pop each at most 1 per clock.
  - Pop occurs at an edge where ft_wr_n_i=0, ft_txe_i=0 and fifo_empty_o=0.
  - Pop while empty is ignored, and the pointers are not moved.
  - Write while full never happens, because the FSM gates on space.
  - Simultaneous write and pop: level unchanged, both pointers advance.
  - Level arithmetic is FIFO_AW+1 bits wide; pointers wrap modulo depth.
- FWFT latency:
  - A byte written at edge k into an empty FIFO appears on fif_data_o, with fifo_empty_o=0, after edge k (1 cycle).
  - After a pop, the next byte is presented after the same edge.
  - fif_data_o is don't-care while fifo_empty_o=1, except that it is 8'h00 after reset.
- Full: level = 2**FIFO_AW. Header writes stall and S_SHI deasserts ready when fewer than 2 entries are free.

Test Plan:
- SMP_PER_FRAME=4, en_i=1, TXE# high; samples 0x123,0xABC,0x000,0xFFF offered on consecutive ready cycles -> FIFO holds exactly A5 5A 00 01 23 0A BC 00 00 0F FF, level=11, fifo_empty_o=0. Then lower TXE# and hold WR# low -> bytes drain in that order, one per clock, and the FIFO ends empty.
- Continuous streaming with TXE# low and WR# low for 300 frames -> consecutive frame seq bytes run 00..FF then 00, 01, ... (wrap at 256), and no drops occur.
- FIFO_AW=4, TXE# held high, valid held high -> level reaches 16 or 15 and holds. ready stays 0; ovf_o=1 and drop_cnt_o increments once per cycle. Forcing drop_cnt_o to 16'hFFFE, then two further drops -> it holds 16'hFFFF.
- Empty FIFO, WR# low and TXE# low -> no pointer movement, level stays 0. Single write -> fifo_empty_o drops exactly one cycle later. Simultaneous pop and write at level 5 -> level stays 5.
- en_i deasserted in the middle of frame payload -> frame completes with all SMP_PER_FRAME samples, then no new HDR0 is written. Re-asserting en_i -> the next frame's header carries seq+1.
- rst_n_i pulsed low mid-payload (asynchronously, between edges) -> all outputs immediately reach their reset values. After release, the first bytes written are A5 5A 00.

Source files
------------

// File: rtl/ft_sample_packer.sv
// ft_sample_packer: frames 12-bit ADC samples into byte packets
// (HDR0, HDR1, seq, then hi/lo byte per sample) and buffers them in a
// first-word-fall-through byte FIFO that feeds the FT232H write driver.
module ft_sample_packer #(
  parameter int         SMP_PER_FRAME = 256,
  parameter int         FIFO_AW       = 10,
  parameter logic [7:0] HDR0          = 8'hA5,
  parameter logic [7:0] HDR1          = 8'h5A
) (
  input  logic               ft_shift_clk,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic [11:0]        smp_data_i,
  input  logic               smp_valid_i,
  output logic               smp_ready_o,
  input  logic               ft_txe_i,
  input  logic               ft_wr_n_i,
  output logic [7:0]         fif_data_o,
  output logic               fifo_empty_o,
  output logic [FIFO_AW:0]   fifo_level_o,
  output logic               ovf_o,
  output logic [15:0]        drop_cnt_o
);

  localparam int               DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] ONE_L    = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0] TWO_L    = (FIFO_AW + 1)'(2);
  localparam logic [15:0]      SMP_LAST = 16'(SMP_PER_FRAME);

  typedef enum logic [2:0] {S_H0, S_H1, S_SEQ, S_SHI, S_SLO} state_t;

  state_t             state, state_nxt;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level, free;
  logic [7:0]         seq, lo_byte, wr_data;
  logic [15:0]        smp_cnt, drop_cnt;
  logic               wr_en, pop, full, room2, accept, ovf;
  logic               seq_inc, cnt_clr, cnt_inc, lo_load;

  assign free         = DEPTH_L - level;
  assign full         = (level == DEPTH_L);
  assign room2        = (free >= TWO_L);
  assign fifo_empty_o = (level == '0);
  assign fifo_level_o = level;
  assign pop          = !ft_wr_n_i && !ft_txe_i && !fifo_empty_o;
  assign smp_ready_o  = (state == S_SHI) && room2;
  assign accept       = smp_valid_i && smp_ready_o;
  assign fif_data_o   = fifo_empty_o ? 8'h00 : mem[rd_ptr];
  assign ovf_o        = ovf;
  assign drop_cnt_o   = drop_cnt;

  // FSM state register
  always_ff @(posedge ft_shift_clk or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_H0;
    else          state <= state_nxt;
  end

  // Next state and FIFO write request; the sample lo byte never checks
  // space because S_SHI only accepts with two free entries
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_data   = HDR0;
    seq_inc   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    lo_load   = 1'b0;
    case (state)
      S_H0: begin
        if (en_i && !full) begin
          wr_en     = 1'b1;
          wr_data   = HDR0;
          state_nxt = S_H1;
        end
      end
      S_H1: begin
        if (!full) begin
          wr_en     = 1'b1;
          wr_data   = HDR1;
          state_nxt = S_SEQ;
        end
      end
      S_SEQ: begin
        if (!full) begin
          wr_en     = 1'b1;
          wr_data   = seq;
          cnt_clr   = 1'b1;
          state_nxt = S_SHI;
        end
      end
      S_SHI: begin
        if (accept) begin
          wr_en     = 1'b1;
          wr_data   = {4'h0, smp_data_i[11:8]};
          lo_load   = 1'b1;
          state_nxt = S_SLO;
        end
      end
      S_SLO: begin
        wr_en   = 1'b1;
        wr_data = lo_byte;
        cnt_inc = 1'b1;
        if (smp_cnt + 16'd1 == SMP_LAST) begin
          seq_inc   = 1'b1;
          state_nxt = S_H0;
        end else begin
          state_nxt = S_SHI;
        end
      end
      default: state_nxt = S_H0;
    endcase
  end

  // Frame bookkeeping: sequence number, sample count, pending lo byte
  always_ff @(posedge ft_shift_clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      seq     <= 8'h00;
      smp_cnt <= 16'h0000;
      lo_byte <= 8'h00;
    end else begin
      if (seq_inc) seq <= seq + 8'd1;
      if (cnt_clr)      smp_cnt <= 16'h0000;
      else if (cnt_inc) smp_cnt <= smp_cnt + 16'd1;
      if (lo_load) lo_byte <= smp_data_i[7:0];
    end
  end

  // FIFO storage; contents need no reset since level gates visibility
  always_ff @(posedge ft_shift_clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge ft_shift_clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + ONE_L;
        2'b01:   level <= level - ONE_L;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge ft_shift_clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf      <= 1'b0;
      drop_cnt <= 16'h0000;
    end else if (smp_valid_i && !smp_ready_o) begin
      ovf <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ft_sample_packer.sv
// Bench for ft_sample_packer: a small framing model pushes expected bytes
// into a queue and a negedge monitor pops and compares every FIFO pop.
module tb_ft_sample_packer;

  localparam int SPF = 4;
  localparam int AW  = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [11:0] smp_data;
  logic        smp_valid;
  logic        smp_ready;
  logic        ft_txe;
  logic        ft_wr_n;
  logic [7:0]  fif_data;
  logic        fifo_empty;
  logic [AW:0] fifo_level;
  logic        ovf;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0]  q[$];
  int          mdl_cnt;
  logic [7:0]  mdl_seq;
  logic        hdr_pushed;
  logic [15:0] mdl_drop;

  ft_sample_packer #(.SMP_PER_FRAME(SPF), .FIFO_AW(AW), .HDR0(8'hA5), .HDR1(8'h5A)) dut (
    .ft_shift_clk(clk), .rst_n_i(rst_n), .en_i(en),
    .smp_data_i(smp_data), .smp_valid_i(smp_valid), .smp_ready_o(smp_ready),
    .ft_txe_i(ft_txe), .ft_wr_n_i(ft_wr_n),
    .fif_data_o(fif_data), .fifo_empty_o(fifo_empty), .fifo_level_o(fifo_level),
    .ovf_o(ovf), .drop_cnt_o(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-byte model and pop scoreboard, evaluated before each rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (en && mdl_cnt == 0 && !hdr_pushed) begin
        q.push_back(8'hA5);
        q.push_back(8'h5A);
        q.push_back(mdl_seq);
        hdr_pushed = 1'b1;
      end
      if (smp_valid && smp_ready) begin
        q.push_back({4'h0, smp_data[11:8]});
        q.push_back(smp_data[7:0]);
        mdl_cnt++;
        if (mdl_cnt == SPF) begin
          mdl_cnt    = 0;
          mdl_seq    = mdl_seq + 8'd1;
          hdr_pushed = 1'b0;
        end
      end
      if (smp_valid && !smp_ready && mdl_drop != 16'hFFFF) mdl_drop = mdl_drop + 16'd1;
      if (!ft_wr_n && !ft_txe && !fifo_empty) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("[TB] FAIL pop_unexpected got=%h want=none", fif_data);
        end else begin
          logic [7:0] exp_b;
          exp_b = q.pop_front();
          if (fif_data !== exp_b) begin
            bad++;
            $display("[TB] FAIL pop_data got=%h want=%h", fif_data, exp_b);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    q.delete();
    mdl_cnt    = 0;
    mdl_seq    = 8'h00;
    hdr_pushed = 1'b0;
    mdl_drop   = 16'h0000;
  endtask

  task automatic send_sample(input logic [11:0] d);
    int n = 0;
    while (!smp_ready && n < 100) begin
      tick();
      n++;
    end
    if (!smp_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL send_timeout got=ready0 want=ready1");
    end else begin
      smp_data  = d;
      smp_valid = 1'b1;
      tick();
      smp_valid = 1'b0;
    end
  endtask

  task automatic wait_drained();
    int n = 0;
    while (!fifo_empty && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (fifo_level !== 5'd0 || fifo_empty !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drain level=%0d empty=%b want level=0 empty=1", fifo_level, fifo_empty);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain_missing got=%0d want=0 bytes outstanding", q.size());
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (fifo_empty !== 1'b1 || fifo_level !== 5'd0 || fif_data !== 8'h00) begin
      bad++;
      $display("[TB] FAIL %s_fifo empty=%b level=%0d data=%h want 1/0/00", tag, fifo_empty, fifo_level, fif_data);
    end
    total++;
    if (smp_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_ready got=%b want=0", tag, smp_ready);
    end
    total++;
    if (ovf !== 1'b0 || drop_cnt !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL %s_drop ovf=%b cnt=%h want 0/0000", tag, ovf, drop_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; smp_valid = 1'b0; smp_data = '0;
    ft_txe = 1'b1; ft_wr_n = 1'b1;
    clear_model();
    #23;
    check_reset_values("reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_values("post_reset");
  endtask

  task automatic test_frame_format();
    logic [7:0] exp_bytes [11];
    exp_bytes = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'h00, 8'h00, 8'h0F, 8'hFF};
    en = 1'b1;
    send_sample(12'h123);
    en = 1'b0;
    send_sample(12'hABC);
    send_sample(12'h000);
    send_sample(12'hFFF);
    repeat (3) tick();
    total++;
    if (fifo_level !== 5'd11 || fifo_empty !== 1'b0) begin
      bad++;
      $display("[TB] FAIL frame_level got=%0d empty=%b want 11/0", fifo_level, fifo_empty);
    end
    ft_txe = 1'b0;
    ft_wr_n = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      total++;
      if (fif_data !== exp_bytes[i] || fifo_empty !== 1'b0) begin
        bad++;
        $display("[TB] FAIL frame_byte%0d got=%h want=%h", i, fif_data, exp_bytes[i]);
      end
    end
    @(negedge clk);
    total++;
    if (fifo_empty !== 1'b1 || fifo_level !== 5'd0) begin
      bad++;
      $display("[TB] FAIL frame_drained empty=%b level=%0d want 1/0", fifo_empty, fifo_level);
    end
    tick();
    ft_txe = 1'b1;
    ft_wr_n = 1'b1;
  endtask

  task automatic test_en_gate();
    ft_txe = 1'b0;
    ft_wr_n = 1'b0;
    en = 1'b1;
    send_sample(12'h111);
    en = 1'b0;
    for (int i = 0; i < SPF - 1; i++) send_sample(12'($urandom));
    wait_drained();
    repeat (20) tick();
    total++;
    if (fifo_level !== 5'd0 || fifo_empty !== 1'b1) begin
      bad++;
      $display("[TB] FAIL en_idle level=%0d empty=%b want 0/1", fifo_level, fifo_empty);
    end
    en = 1'b1;
    send_sample(12'h222);
    en = 1'b0;
    for (int i = 0; i < SPF - 1; i++) send_sample(12'($urandom));
    wait_drained();
    ft_txe = 1'b1;
    ft_wr_n = 1'b1;
  endtask

  task automatic test_full_drop();
    logic [15:0] d0;
    en = 1'b1;
    smp_data = 12'h5A5;
    smp_valid = 1'b1;
    repeat (40) tick();
    en = 1'b0;
    total++;
    if (fifo_level !== 5'd16 || q.size() != 16) begin
      bad++;
      $display("[TB] FAIL full_level got=%0d model=%0d want=16", fifo_level, q.size());
    end
    total++;
    if (smp_ready !== 1'b0 || ovf !== 1'b1) begin
      bad++;
      $display("[TB] FAIL full_flags ready=%b ovf=%b want 0/1", smp_ready, ovf);
    end
    total++;
    if (drop_cnt !== mdl_drop) begin
      bad++;
      $display("[TB] FAIL full_dropcnt got=%h want=%h", drop_cnt, mdl_drop);
    end
    d0 = mdl_drop;
    repeat (5) tick();
    total++;
    if (drop_cnt !== d0 + 16'd5) begin
      bad++;
      $display("[TB] FAIL drop_rate got=%h want=%h", drop_cnt, d0 + 16'd5);
    end
    force dut.drop_cnt = 16'hFFFE;
    mdl_drop = 16'hFFFE;
    release dut.drop_cnt;
    repeat (3) tick();
    total++;
    if (drop_cnt !== 16'hFFFF || mdl_drop !== 16'hFFFF) begin
      bad++;
      $display("[TB] FAIL drop_saturate got=%h want=ffff", drop_cnt);
    end
    smp_valid = 1'b0;
    ft_txe = 1'b0;
    ft_wr_n = 1'b0;
    for (int i = 0; i < SPF - 1; i++) send_sample(12'($urandom));
    wait_drained();
    ft_txe = 1'b1;
    ft_wr_n = 1'b1;
  endtask

  task automatic test_empty_pop();
    ft_txe = 1'b0;
    ft_wr_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (fifo_level !== 5'd0 || fifo_empty !== 1'b1) begin
        bad++;
        $display("[TB] FAIL empty_pop level=%0d empty=%b want 0/1", fifo_level, fifo_empty);
      end
    end
    ft_txe = 1'b1;
    ft_wr_n = 1'b1;
    en = 1'b1;
    @(negedge clk);
    total++;
    if (fifo_empty !== 1'b1) begin
      bad++;
      $display("[TB] FAIL fwft_before got=%b want=1", fifo_empty);
    end
    @(negedge clk);
    total++;
    if (fifo_empty !== 1'b0 || fif_data !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL fwft_after empty=%b data=%h want 0/a5", fifo_empty, fif_data);
    end
    tick();
    en = 1'b0;
    send_sample(12'h321);
    tick();
    total++;
    if (fifo_level !== 5'd5) begin
      bad++;
      $display("[TB] FAIL level5_setup got=%0d want=5", fifo_level);
    end
    ft_txe = 1'b0;
    ft_wr_n = 1'b0;
    send_sample(12'h654);
    total++;
    if (fifo_level !== 5'd5) begin
      bad++;
      $display("[TB] FAIL simul_hi got=%0d want=5", fifo_level);
    end
    tick();
    total++;
    if (fifo_level !== 5'd5) begin
      bad++;
      $display("[TB] FAIL simul_lo got=%0d want=5", fifo_level);
    end
    ft_txe = 1'b1;
    ft_wr_n = 1'b1;
    for (int i = 0; i < SPF - 2; i++) send_sample(12'($urandom));
    ft_txe = 1'b0;
    ft_wr_n = 1'b0;
    wait_drained();
    ft_txe = 1'b1;
    ft_wr_n = 1'b1;
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    send_sample(12'h777);
    send_sample(12'h888);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    clear_model();
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (fifo_empty !== 1'b0 || fif_data !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL restart_head empty=%b data=%h want 0/a5", fifo_empty, fif_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    ft_txe = 1'b0;
    ft_wr_n = 1'b0;
    for (int f = 0; f < 300; f++) begin
      for (int s = 0; s < SPF; s++) begin
        if (f == 299 && s == 1) en = 1'b0;
        send_sample(12'($urandom));
      end
    end
    wait_drained();
    total++;
    if (drop_cnt !== 16'h0000 || ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stream_drops cnt=%h ovf=%b want 0000/0", drop_cnt, ovf);
    end
    ft_txe = 1'b1;
    ft_wr_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_frame_format();
    test_en_gate();
    test_full_drop();
    test_empty_pop();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
